key_schedule_ctrl: RTL and testbench

Sequencer that drives the single-round subkey generator (GenSubKey) to perform full AES-128 key expansion. It accepts a cipher key over a valid/ready handshake and issues 10 rounds to the generator, supplying the Rcon word and the previous round key for each. It captures every returned subkey into an 11-entry round-key file, which the cipher datapath reads by index. It is latency-agnostic towards the generator and waits on that block's valid_out, not on a fixed cycle count.

---
 rtl/key_schedule_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_key_schedule_ctrl.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_schedule_ctrl
// Description : Sequencer for AES-128 key expansion around an external
//               single-round subkey generator (GenSubKey). Accepts a cipher
//               key over a valid/ready handshake and issues NUM_ROUNDS
//               requests to the generator. Each request carries the Rcon word
//               and the previous round key. Every returned subkey is stored in
//               an (NUM_ROUNDS+1)-entry round-key file. The file is read
//               combinationally by index. The controller waits on the
//               generator's valid_out, so it works with any generator latency.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: KEYSCHED_TIMEOUT_EN
//   Defined   : adds output err and a per-round watchdog. A round whose
//               result has not returned after TIMEOUT_CYCLES cycles in WAIT
//               aborts the expansion and sets err. The next accepted key
//               clears err.
//   Undefined : no err port. WAIT waits for the generator indefinitely.
// ----------------------------------------------------------------------------
// Ports:
//   clk           in   1         clock, rising edge
//   reset         in   1         asynchronous active-low reset
//   key_in        in   KEY_LEN   cipher key
//   key_valid     in   1         key_in valid
//   key_ready     out  1         key accepted this cycle (high in IDLE)
//   gsk_rcon      out  WORD_LEN  Rcon word to the generator
//   gsk_key       out  KEY_LEN   previous round key to the generator
//   gsk_valid_in  out  1         one-cycle request strobe to the generator
//   gsk_key_ret   in   KEY_LEN   subkey returned by the generator
//   gsk_valid_out in   1         generator result valid
//   rk_idx        in   4         round-key read index
//   rk_data       out  KEY_LEN   round key at rk_idx (0 when out of range)
//   busy          out  1         expansion in progress
//   keys_valid    out  1         complete, consistent round-key set present
//   err           out  1         watchdog expired (KEYSCHED_TIMEOUT_EN only)
// ============================================================================
module key_schedule_ctrl #(
  parameter int KEY_LEN        = 128,
  parameter int WORD_LEN       = 32,
  parameter int NUM_ROUNDS     = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [KEY_LEN-1:0]  key_in,
  input  logic                key_valid,
  output logic                key_ready,
  output logic [WORD_LEN-1:0] gsk_rcon,
  output logic [KEY_LEN-1:0]  gsk_key,
  output logic                gsk_valid_in,
  input  logic [KEY_LEN-1:0]  gsk_key_ret,
  input  logic                gsk_valid_out,
  input  logic [3:0]          rk_idx,
  output logic [KEY_LEN-1:0]  rk_data,
  output logic                busy,
  output logic                keys_valid
`ifdef KEYSCHED_TIMEOUT_EN
  ,
  output logic                err
`endif
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // --------------------------------------------------------------------------
  // The round counter and read index are 4 bits wide, and the Rcon byte
  // occupies the top byte of the Rcon word.
  if ((NUM_ROUNDS < 1) || (NUM_ROUNDS > 15)) begin : g_chk_rounds
    $error("key_schedule_ctrl: NUM_ROUNDS must be in 1..15");
  end
  if (WORD_LEN < 9) begin : g_chk_word
    $error("key_schedule_ctrl: WORD_LEN must be at least 9");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
    $error("key_schedule_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [3:0]         round_q, round_d;       // round currently being generated
  logic [7:0]         rcon_q, rcon_d;         // Rcon top byte; low bits are zero
  logic               keys_valid_q, keys_valid_d;
  logic [KEY_LEN-1:0] rk_q [NUM_ROUNDS+1];
  logic [KEY_LEN-1:0] rk_d [NUM_ROUNDS+1];

`ifdef KEYSCHED_TIMEOUT_EN
  localparam int         WD_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            err_q, err_d;
`endif

  // GF(2^8) doubling of the current Rcon byte gives the next round's Rcon.
  logic [7:0] rcon_next;
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    rcon_d       = rcon_q;
    keys_valid_d = keys_valid_q;
    rk_d         = rk_q;
`ifdef KEYSCHED_TIMEOUT_EN
    wdog_d       = wdog_q;
    err_d        = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Accepting a new key invalidates the previous set on the same edge.
        if (key_valid) begin
          rk_d[0]      = key_in;
          round_d      = 4'd1;
          rcon_d       = RCON_INIT;
          keys_valid_d = 1'b0;
`ifdef KEYSCHED_TIMEOUT_EN
          err_d        = 1'b0;
`endif
          state_d      = S_ISSUE;
        end
      end

      S_ISSUE: begin
`ifdef KEYSCHED_TIMEOUT_EN
        wdog_d  = '0;
`endif
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // Only the first valid cycle in WAIT is captured. Leaving WAIT on
        // that cycle means a held valid_out lands in ISSUE, which ignores it.
        if (gsk_valid_out) begin
          rk_d[round_q] = gsk_key_ret;
          if (round_q == LAST_ROUND) begin
            keys_valid_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            round_d = round_q + 4'd1;
            rcon_d  = rcon_next;
            state_d = S_ISSUE;
          end
        end
`ifdef KEYSCHED_TIMEOUT_EN
        else if (wdog_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      round_q      <= 4'd0;
      rcon_q       <= RCON_INIT;
      keys_valid_q <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      rcon_q       <= rcon_d;
      keys_valid_q <= keys_valid_d;
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        rk_q[i] <= rk_d[i];
      end
    end
  end

`ifdef KEYSCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign key_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign keys_valid   = keys_valid_q;
  assign gsk_valid_in = (state_q == S_ISSUE);
  assign gsk_rcon     = {rcon_q, {(WORD_LEN-8){1'b0}}};

  // The previous round key stays stable through WAIT. The capture writes
  // rk[round], never rk[round-1]. IDLE drives zero.
  assign gsk_key = (state_q == S_IDLE) ? '0 : rk_q[round_q - 4'd1];

  assign rk_data = (rk_idx <= LAST_ROUND) ? rk_q[rk_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_key_schedule_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_schedule_ctrl
// Description : Self-checking bench for key_schedule_ctrl. A behavioural
//               AES-128 round generator answers the controller's requests.
//               A scoreboard queues the expected Rcon and previous-key pair
//               for each round when a key is accepted. It pops one pair per
//               gsk_valid_in pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_schedule_ctrl;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam int WAIT_LIMIT = 400;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [31:0]  gsk_rcon;
  logic [127:0] gsk_key;
  logic         gsk_valid_in;
  logic [127:0] gsk_key_ret = '0;
  logic         gsk_valid_out = 1'b0;
  logic [3:0]   rk_idx = 4'd0;
  logic [127:0] rk_data;
  logic         busy;
  logic         keys_valid;
`ifdef KEYSCHED_TIMEOUT_EN
  logic         err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  key_schedule_ctrl dut (
    .clk          (clk),
    .reset        (rst_n),
    .key_in       (key_in),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .gsk_rcon     (gsk_rcon),
    .gsk_key      (gsk_key),
    .gsk_valid_in (gsk_valid_in),
    .gsk_key_ret  (gsk_key_ret),
    .gsk_valid_out(gsk_valid_out),
    .rk_idx       (rk_idx),
    .rk_data      (rk_data),
    .busy         (busy),
    .keys_valid   (keys_valid)
`ifdef KEYSCHED_TIMEOUT_EN
    ,
    .err          (err)
`endif
  );

  // --------------------------------------------------------------------------
  // AES-128 reference model
  // --------------------------------------------------------------------------
  logic [7:0] rcon_tab [10];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // --------------------------------------------------------------------------
  // Generator model (sole driver of gsk_valid_out / gsk_key_ret)
  // --------------------------------------------------------------------------
  int           gen_lat = 1;     // cycles from request to result
  int           gen_hold = 1;    // cycles valid_out stays high (use with lat 1)
  bit           gen_stall = 1'b0;
  int           stray_n = 0;     // requested stray pulses
  int           stray_done = 0;
  int           gen_cnt = 0;
  int           hold_left = 0;
  logic [127:0] gen_res = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      gen_cnt = 0; hold_left = 0; gsk_valid_out = 1'b0;
    end else begin
      if (gen_cnt > 0) begin
        gen_cnt--;
        if (gen_cnt == 0) begin
          gsk_valid_out = 1'b1; gsk_key_ret = gen_res; hold_left = gen_hold - 1;
        end else begin
          gsk_valid_out = 1'b0; hold_left = 0;
        end
      end else if (hold_left > 0) begin
        hold_left--;
      end else if (stray_done < stray_n) begin
        gsk_valid_out = 1'b1; gsk_key_ret = '1; stray_done++;
      end else begin
        gsk_valid_out = 1'b0;
      end
      if (gsk_valid_in && !gen_stall) begin
        gen_res = aes_next(gsk_key, gsk_rcon[31:24]);
        gen_cnt = gen_lat;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard: push on key acceptance, pop on each generator request
  // --------------------------------------------------------------------------
  logic [7:0]   exp_rcon_q [$];
  logic [127:0] exp_key_q [$];
  logic [127:0] mk, ek;
  logic [7:0]   er;
  bit           prev_vin = 1'b0;
  int           n_pulses = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_rcon_q.delete(); exp_key_q.delete(); prev_vin = 1'b0;
    end else begin
      if (key_valid && key_ready) begin
        exp_rcon_q.delete(); exp_key_q.delete();
        mk = key_in;
        for (int i = 0; i < 10; i++) begin
          exp_key_q.push_back(mk);
          exp_rcon_q.push_back(rcon_tab[i]);
          mk = aes_next(mk, rcon_tab[i]);
        end
      end
      if (gsk_valid_in) begin
        n_pulses++;
        n_checks++;
        if (prev_vin) begin
          n_errors++;
          $display("FAIL issue_width: gsk_valid_in high on consecutive cycles, required 1-cycle pulse");
        end
        n_checks++;
        if (exp_rcon_q.size() == 0) begin
          n_errors++;
          $display("FAIL issue_extra: unexpected request rcon=%h, required no request", gsk_rcon);
        end else begin
          er = exp_rcon_q.pop_front();
          ek = exp_key_q.pop_front();
          if (gsk_rcon !== {er, 24'h0} || gsk_key !== ek) begin
            n_errors++;
            $display("FAIL issue_data: rcon=%h key=%h, required rcon=%h key=%h",
                     gsk_rcon, gsk_key, {er, 24'h0}, ek);
          end
        end
      end
      prev_vin = gsk_valid_in;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (no comparisons inside)
  // --------------------------------------------------------------------------
  task automatic drive_key(input logic [127:0] k, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    key_in = k; key_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (key_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_keys_valid(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < WAIT_LIMIT; c++) begin
      @(negedge clk);
      if (keys_valid) begin ok = 1'b1; break; end
    end
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (key_ready !== 1'b1 || busy !== 1'b0 || keys_valid !== 1'b0 || gsk_valid_in !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: ready=%b busy=%b kv=%b vin=%b, required 1 0 0 0",
               key_ready, busy, keys_valid, gsk_valid_in);
    end
    n_checks++;
    if (gsk_key !== 128'h0 || gsk_rcon !== 32'h01000000) begin
      n_errors++;
      $display("FAIL reset_gsk: key=%h rcon=%h, required 0 and 01000000", gsk_key, gsk_rcon);
    end
    for (int i = 0; i < 11; i++) begin
      rk_idx = 4'(i); #1;
      n_checks++;
      if (rk_data !== 128'h0) begin
        n_errors++;
        $display("FAIL reset_rk[%0d]: got %h, required 0", i, rk_data);
      end
    end
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_fips_key;
    bit ok;
    int base;
    logic [127:0] k;
    gen_lat = 3;
    base = n_pulses;
    drive_key(FIPS_KEY, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL fips_accept: key not accepted, required accept"); end
    wait_keys_valid(ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL fips_done: keys_valid never set, required 1"); end
    n_checks++;
    if (busy !== 1'b0 || key_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL fips_idle: busy=%b ready=%b, required 0 1", busy, key_ready);
    end
    n_checks++;
    if (n_pulses - base != 10 || exp_rcon_q.size() != 0) begin
      n_errors++;
      $display("FAIL fips_pulses: got %0d requests (%0d unissued), required 10 (0)",
               n_pulses - base, exp_rcon_q.size());
    end
    rk_idx = 4'd1; #1;
    n_checks++;
    if (rk_data !== FIPS_RK1) begin
      n_errors++; $display("FAIL fips_rk1: got %h, required %h", rk_data, FIPS_RK1);
    end
    rk_idx = 4'd10; #1;
    n_checks++;
    if (rk_data !== FIPS_RK10) begin
      n_errors++; $display("FAIL fips_rk10: got %h, required %h", rk_data, FIPS_RK10);
    end
    k = FIPS_KEY;
    for (int i = 0; i < 11; i++) begin
      rk_idx = 4'(i); #1;
      n_checks++;
      if (rk_data !== k) begin
        n_errors++; $display("FAIL fips_rk[%0d]: got %h, required %h", i, rk_data, k);
      end
      if (i < 10) k = aes_next(k, rcon_tab[i]);
    end
    for (int i = 11; i < 16; i++) begin
      rk_idx = 4'(i); #1;
      n_checks++;
      if (rk_data !== 128'h0) begin
        n_errors++; $display("FAIL rk_oob[%0d]: got %h, required 0", i, rk_data);
      end
    end
  endtask

  task automatic test_stray_valid;
    logic [127:0] k;
    stray_n = stray_n + 2;
    repeat (6) @(negedge clk);
    #1;
    n_checks++;
    if (keys_valid !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL stray_ctrl: kv=%b busy=%b, required 1 0", keys_valid, busy);
    end
    k = FIPS_KEY;
    for (int i = 0; i < 11; i++) begin
      rk_idx = 4'(i); #1;
      n_checks++;
      if (rk_data !== k) begin
        n_errors++; $display("FAIL stray_rk[%0d]: got %h, required %h", i, rk_data, k);
      end
      if (i < 10) k = aes_next(k, rcon_tab[i]);
    end
  endtask

  task automatic test_held_valid;
    bit ok;
    int base;
    logic [127:0] key, k;
    key = {$urandom, $urandom, $urandom, $urandom};
    gen_lat = 1; gen_hold = 2;
    base = n_pulses;
    drive_key(key, ok);
    wait_keys_valid(ok);
    n_checks++;
    if (!ok || n_pulses - base != 10) begin
      n_errors++;
      $display("FAIL held_done: kv_seen=%b requests=%0d, required 1 and 10", ok, n_pulses - base);
    end
    k = key;
    for (int i = 0; i < 11; i++) begin
      rk_idx = 4'(i); #1;
      n_checks++;
      if (rk_data !== k) begin
        n_errors++; $display("FAIL held_rk[%0d]: got %h, required %h", i, rk_data, k);
      end
      if (i < 10) k = aes_next(k, rcon_tab[i]);
    end
    repeat (3) @(negedge clk);
    gen_hold = 1;
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [127:0] ka, kb, k;
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = ~ka;
    gen_lat = 2;
    rk_idx = 4'd10;
    @(posedge clk); #1;
    key_in = ka; key_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (key_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    key_in = kb;                        // key_valid stays high
    ok = 1'b0;
    for (int c = 0; c < WAIT_LIMIT; c++) begin
      @(negedge clk);
      if (keys_valid) begin ok = 1'b1; break; end
      if (busy) begin
        n_checks++;
        if (key_ready !== 1'b0) begin
          n_errors++; $display("FAIL busy_ready: key_ready=%b while busy, required 0", key_ready);
        end
      end
    end
    k = ka;
    for (int i = 0; i < 10; i++) k = aes_next(k, rcon_tab[i]);
    n_checks++;
    if (!ok || rk_data !== k) begin
      n_errors++; $display("FAIL b2b_first: rk10=%h, required %h", rk_data, k);
    end
    @(posedge clk); #1;
    key_valid = 1'b0;
    wait_keys_valid(ok);
    k = kb;
    for (int i = 0; i < 10; i++) k = aes_next(k, rcon_tab[i]);
    n_checks++;
    if (!ok || rk_data !== k) begin
      n_errors++; $display("FAIL b2b_second: rk10=%h, required %h", rk_data, k);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int base;
    logic [127:0] key, k;
    gen_lat = 2;
    base = n_pulses;
    drive_key({$urandom, $urandom, $urandom, $urandom}, ok);
    ok = 1'b0;
    for (int c = 0; c < WAIT_LIMIT; c++) begin
      @(negedge clk); #1;
      if (n_pulses - base == 5) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL mid_round5: round 5 not reached, required reach"); end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (keys_valid !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1 || gsk_rcon !== 32'h01000000) begin
      n_errors++;
      $display("FAIL mid_reset: kv=%b busy=%b ready=%b rcon=%h, required 0 0 1 01000000",
               keys_valid, busy, key_ready, gsk_rcon);
    end
    for (int i = 0; i < 11; i++) begin
      rk_idx = 4'(i); #1;
      n_checks++;
      if (rk_data !== 128'h0) begin
        n_errors++; $display("FAIL mid_rk[%0d]: got %h, required 0", i, rk_data);
      end
    end
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    key = {$urandom, $urandom, $urandom, $urandom};
    base = n_pulses;
    drive_key(key, ok);
    wait_keys_valid(ok);
    n_checks++;
    if (!ok || n_pulses - base != 10) begin
      n_errors++;
      $display("FAIL mid_restart: kv_seen=%b requests=%0d, required 1 and 10", ok, n_pulses - base);
    end
    k = key;
    for (int i = 0; i < 10; i++) k = aes_next(k, rcon_tab[i]);
    rk_idx = 4'd10; #1;
    n_checks++;
    if (rk_data !== k) begin
      n_errors++; $display("FAIL mid_rk10: got %h, required %h", rk_data, k);
    end
  endtask

`ifdef KEYSCHED_TIMEOUT_EN
  task automatic test_timeout;
    bit ok;
    int base;
    gen_lat = 1;
    base = n_pulses;
    drive_key(FIPS_KEY, ok);
    ok = 1'b0;
    for (int c = 0; c < WAIT_LIMIT; c++) begin
      @(negedge clk); #1;
      if (n_pulses - base == 2) begin ok = 1'b1; break; end
    end
    gen_stall = 1'b1;
    for (int c = 0; c < WAIT_LIMIT; c++) begin
      if (n_pulses - base == 3) break;
      @(negedge clk); #1;
    end
    n_checks++;
    if (!ok || n_pulses - base != 3) begin
      n_errors++; $display("FAIL to_round3: requests=%0d, required 3", n_pulses - base);
    end
    repeat (16) @(negedge clk);
    #1;
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_errors++; $display("FAIL to_early: err=%b busy=%b after 15 WAIT cycles, required 0 1", err, busy);
    end
    @(negedge clk); #1;
    n_checks++;
    if (err !== 1'b1 || keys_valid !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL to_expire: err=%b kv=%b busy=%b ready=%b, required 1 0 0 1",
               err, keys_valid, busy, key_ready);
    end
    gen_stall = 1'b0;
    drive_key(FIPS_KEY, ok);
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++; $display("FAIL to_clear: err=%b after new key, required 0", err);
    end
    wait_keys_valid(ok);
    rk_idx = 4'd10; #1;
    n_checks++;
    if (!ok || rk_data !== FIPS_RK10 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL to_recover: kv_seen=%b rk10=%h err=%b, required 1 %h 0", ok, rk_data, err, FIPS_RK10);
    end
  endtask
`endif

  initial begin
    rcon_tab[0] = 8'h01; rcon_tab[1] = 8'h02; rcon_tab[2] = 8'h04; rcon_tab[3] = 8'h08;
    rcon_tab[4] = 8'h10; rcon_tab[5] = 8'h20; rcon_tab[6] = 8'h40; rcon_tab[7] = 8'h80;
    rcon_tab[8] = 8'h1b; rcon_tab[9] = 8'h36;
    test_reset();
    test_fips_key();
    test_stray_valid();
    test_held_valid();
    test_back_to_back();
    test_reset_mid();
`ifdef KEYSCHED_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
